// File: rtl/sdram_init_seq.sv
`timescale 1ns/1ps
// sdram_init_seq: drives the SDRAM power-up command sequence (CKE/NOP wait,
// PRECHARGE-ALL, AUTO-REFRESH burst, LOAD MODE REGISTER). It owns the command
// bus until init_done and can be re-run from DONE via init_req.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_RST_NOP   | power-up stabilisation, NOP with CKE high
// ST_PRE       | PRECHARGE-ALL on the bus this cycle
// ST_WAIT_TRP  | NOPs covering tRP
// ST_AREF      | AUTO-REFRESH on the bus this cycle
// ST_WAIT_TRFC | NOPs covering tRFC
// ST_LMR       | LOAD MODE REGISTER on the bus this cycle
// ST_WAIT_TMRD | NOPs covering tMRD
// ST_DONE      | DESELECT, bus released, waiting for a re-init request
//
// The state register names the command currently on the output pins; the wait
// counter hits 0 on the last NOP of each wait, and the following edge issues
// the next command.
module sdram_init_seq #(
    parameter int INIT_NOP_CYC = 500,
    parameter int TRP_CYC      = 3,
    parameter int TRFC_CYC     = 7,
    parameter int TMRD_CYC     = 2,
    parameter int REF_CNT      = 2,
    parameter int SDR_ADDR_W   = 13,
    parameter int SDR_BA_W     = 2
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_resetn,
    input  logic [SDR_ADDR_W-1:0] cfg_sdr_mode_reg,
    input  logic                  init_req,
    output logic                  sdr_cke,
    output logic                  sdr_cs_n,
    output logic                  sdr_ras_n,
    output logic                  sdr_cas_n,
    output logic                  sdr_we_n,
    output logic [SDR_ADDR_W-1:0] sdr_addr,
    output logic [SDR_BA_W-1:0]   sdr_ba,
    output logic                  init_busy,
    output logic                  init_done
);

    localparam int MAX_A    = (INIT_NOP_CYC > TRP_CYC) ? INIT_NOP_CYC : TRP_CYC;
    localparam int MAX_B    = (TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam logic [3:0] CMD_DES  = 4'b1111;

    // PRECHARGE-ALL is selected by A10 alone
    localparam logic [SDR_ADDR_W-1:0] PRE_ALL_ADDR = SDR_ADDR_W'(1) << 10;

    typedef enum logic [2:0] {
        ST_RST_NOP,
        ST_PRE,
        ST_WAIT_TRP,
        ST_AREF,
        ST_WAIT_TRFC,
        ST_LMR,
        ST_WAIT_TMRD,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_ref;
    logic             r_req;

    // Sequencer: state, wait/refresh counters and all registered pin outputs
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state   <= ST_RST_NOP;
            r_cnt     <= CNT_W'(INIT_NOP_CYC);
            r_ref     <= '0;
            r_req     <= 1'b0;
            sdr_cke   <= 1'b0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_DES;
            sdr_addr  <= '0;
            sdr_ba    <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            // CKE never drops once raised; every cycle outside DONE is busy
            sdr_cke   <= 1'b1;
            init_busy <= 1'b1;
            init_done <= 1'b0;
            sdr_addr  <= '0;
            sdr_ba    <= '0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;

            case (r_state)
                ST_RST_NOP: begin
                    if (r_cnt == '0) begin
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_PRE;
                        sdr_addr <= PRE_ALL_ADDR;
                        r_ref    <= '0;
                        r_state  <= ST_PRE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_PRE: begin
                    r_cnt   <= CNT_W'(TRP_CYC - 1);
                    r_state <= ST_WAIT_TRP;
                end
                ST_WAIT_TRP: begin
                    if (r_cnt == '0) begin
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_AREF;
                        r_ref   <= r_ref + 4'd1;
                        r_state <= ST_AREF;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_AREF: begin
                    r_cnt   <= CNT_W'(TRFC_CYC - 1);
                    r_state <= ST_WAIT_TRFC;
                end
                ST_WAIT_TRFC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_ref < 4'(REF_CNT)) begin
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_AREF;
                        r_ref   <= r_ref + 4'd1;
                        r_state <= ST_AREF;
                    end else begin
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_LMR;
                        sdr_addr <= cfg_sdr_mode_reg;
                        r_state  <= ST_LMR;
                    end
                end
                ST_LMR: begin
                    r_cnt   <= CNT_W'(TMRD_CYC - 1);
                    r_state <= ST_WAIT_TMRD;
                end
                ST_WAIT_TMRD: begin
                    if (r_cnt == '0) begin
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_DES;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // a request seen here launches PRECHARGE on the following edge
                    if (r_req) begin
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_PRE;
                        sdr_addr <= PRE_ALL_ADDR;
                        r_ref    <= '0;
                        r_req    <= 1'b0;
                        r_state  <= ST_PRE;
                    end else begin
                        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_DES;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                        r_req     <= init_req;
                    end
                end
                default: begin
                    r_state <= ST_RST_NOP;
                    r_cnt   <= CNT_W'(INIT_NOP_CYC);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
`timescale 1ns/1ps
// Testbench for sdram_init_seq: a default-parameter instance and a short-timing
// instance, each compared cycle by cycle against a timeline model of the
// power-up command sequence.
module tb_sdram_init_seq;

    logic        clk = 1'b0;
    logic        rst0, rst1, req0, req1;
    logic [12:0] cfg0, cfg1;

    logic        cke0, cs0, ras0, cas0, we0, busy0, done0;
    logic [12:0] addr0;
    logic [1:0]  ba0;
    logic        cke1, cs1, ras1, cas1, we1, busy1, done1;
    logic [12:0] addr1;
    logic [1:0]  ba1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_init_seq u0 (
        .sdram_clk(clk), .sdram_resetn(rst0), .cfg_sdr_mode_reg(cfg0), .init_req(req0),
        .sdr_cke(cke0), .sdr_cs_n(cs0), .sdr_ras_n(ras0), .sdr_cas_n(cas0), .sdr_we_n(we0),
        .sdr_addr(addr0), .sdr_ba(ba0), .init_busy(busy0), .init_done(done0)
    );

    sdram_init_seq #(
        .INIT_NOP_CYC(10), .TRP_CYC(1), .TRFC_CYC(1), .TMRD_CYC(1), .REF_CNT(4)
    ) u1 (
        .sdram_clk(clk), .sdram_resetn(rst1), .cfg_sdr_mode_reg(cfg1), .init_req(req1),
        .sdr_cke(cke1), .sdr_cs_n(cs1), .sdr_ras_n(ras1), .sdr_cas_n(cas1), .sdr_we_n(we1),
        .sdr_addr(addr1), .sdr_ba(ba1), .init_busy(busy1), .init_done(done1)
    );

    wire [21:0] obs0 = {cke0, cs0, ras0, cas0, we0, busy0, done0, ba0, addr0};
    wire [21:0] obs1 = {cke1, cs1, ras1, cas1, we1, busy1, done1, ba1, addr1};

    // Expected pins at edge k of a sequence (k=0: reset). from_pre: re-init start.
    function automatic logic [21:0] model(int k, bit from_pre, logic [12:0] mode,
                                          int init_c, int trp, int trfc, int tmrd, int refc);
        logic [3:0]  cmd;
        logic [12:0] a;
        logic        busy, done;
        int p, t, u;
        if (k <= 0) return {1'b0, 4'hF, 1'b0, 1'b0, 2'b00, 13'h0};
        cmd = 4'b0111; a = 13'h0; busy = 1'b1; done = 1'b0;
        p = from_pre ? k : k - init_c;
        if (p == 1) begin
            cmd = 4'b0010; a = 13'h400;
        end else if (p > 1 + trp) begin
            t = p - 1 - trp;
            if (t <= refc * (1 + trfc)) begin
                if ((t - 1) % (1 + trfc) == 0) cmd = 4'b0001;
            end else begin
                u = t - refc * (1 + trfc);
                if (u == 1) begin
                    cmd = 4'b0000; a = mode;
                end else if (u > 1 + tmrd) begin
                    cmd = 4'hF; busy = 1'b0; done = 1'b1;
                end
            end
        end
        return {1'b1, cmd, busy, done, 2'b00, a};
    endfunction

    function automatic logic [21:0] m0(int k, bit from_pre, logic [12:0] mode);
        return model(k, from_pre, mode, 500, 3, 7, 2, 2);
    endfunction

    task automatic chk(string tag, logic [21:0] obs, logic [21:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full default sequence with a busy-time request, reset mid-run, then a rerun.
    task automatic seq_with_reset(int rst_edge, int req_a, int req_b, logic [12:0] mode);
        rst0 = 1'b0; req0 = 1'b0; cfg0 = mode;
        @(negedge clk); @(negedge clk);
        chk("reset_hold", obs0, m0(0, 0, mode));
        rst0 = 1'b1;
        for (int e = 1; e < rst_edge; e++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("pre_rst e%0d", e), obs0, m0(e, 0, mode));
            req0 = (e + 1 == req_a);
        end
        @(posedge clk); #2 rst0 = 1'b0; req0 = 1'b0;
        #1 chk($sformatf("async_rst e%0d", rst_edge), obs0, m0(0, 0, mode));
        @(negedge clk); @(negedge clk);
        rst0 = 1'b1;
        for (int e = 1; e <= 530; e++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("restart e%0d", e), obs0, m0(e, 0, mode));
            req0 = (e + 1 == req_b);
        end
        req0 = 1'b0;
    endtask

    logic [12:0] new_mode;

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        cfg0 = 13'h033; cfg1 = 13'($urandom);
        repeat (3) @(negedge clk);
        chk("reset u0", obs0, m0(0, 0, cfg0));
        chk("reset u1", obs1, model(0, 0, cfg1, 10, 1, 1, 1, 4));

        // Short timing: AREF at 13/15/17/19, LMR at 21, done at 23
        rst1 = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("short e%0d", e), obs1, model(e, 0, cfg1, 10, 1, 1, 1, 4));
        end

        // Default timing, ignored request at 300, re-init request at 600
        new_mode = 13'($urandom);
        rst0 = 1'b1;
        for (int e = 1; e <= 640; e++) begin
            @(posedge clk); @(negedge clk);
            if (e <= 600) chk($sformatf("dflt e%0d", e), obs0, m0(e, 0, 13'h033));
            else          chk($sformatf("reinit e%0d", e), obs0, m0(e - 600, 1, new_mode));
            req0 = (e == 299 || e == 599);
            if (e == 600) cfg0 = new_mode;
        end

        // Reset between the two refreshes, then randomized variants
        seq_with_reset(510, 0, 0, 13'h033);
        for (int i = 0; i < 3; i++) begin
            int re;
            re = int'($urandom_range(2, 523));
            seq_with_reset(re, int'($urandom_range(1, 523)), int'($urandom_range(1, 523)),
                           13'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
